// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared definitions for the ALU-sharing arbiter: the opcode set understood
// by the shared 4-bit ALU and the state encodings of the transaction FSM.
// No ports; imported by alu_share_arbiter and rr_pick.
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    typedef logic [2:0] opcode_t;

    // ALU opcodes; 3'b110 and 3'b111 are illegal and flag an error
    localparam opcode_t OP_ADD  = 3'b000;
    localparam opcode_t OP_SUB  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_XOR  = 3'b011;
    localparam opcode_t OP_CAT  = 3'b100;
    localparam opcode_t OP_RAND = 3'b101;

    // Transaction FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Starting just after the requester that
// won last time, it finds the first asserted request (wrapping modulo NREQ).
// Ports:
//   i_req     [NREQ-1:0]  pending requests
//   i_last    [IDW-1:0]   id of the previous winner
//   o_onehot  [NREQ-1:0]  one-hot winner (all zero when no request)
//   o_id      [IDW-1:0]   index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module rr_pick
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [NREQ-1:0] o_onehot,
    output logic [IDW-1:0]  o_id
);

    // IDW+1 bits hold any value up to 2*NREQ-1, enough for start + offset
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW:0]      w_shamt;
    logic [IDW:0]      w_off;
    logic [IDW:0]      w_sum;

    // Rotate the request vector so the highest-priority requester lands in
    // bit 0, take the lowest set bit, then map the offset back to an index.
    always_comb begin
        w_dbl   = {i_req, i_req};
        w_shamt = {1'b0, i_last} + (IDW+1)'(1);
        w_rot   = NREQ'(w_dbl >> w_shamt);
        w_off   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = (IDW+1)'(j);
            end
        end
        w_sum = w_shamt + w_off;
        if (w_sum >= NREQ_W) begin
            w_sum = w_sum - NREQ_W;
        end
        o_id     = IDW'(w_sum);
        o_onehot = NREQ'(1) << o_id;
        if (i_req == '0) begin
            o_id     = '0;
            o_onehot = '0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one 4-bit ALU between NREQ requesters. A round-robin pick in IDLE
// latches the winner's operands and opcode, EXEC evaluates the ALU and
// registers the 8-bit result, RESP holds it under a valid/ready handshake.
// Ports:
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_req   [NREQ-1:0]    per-requester request
//   i_a_in  [4*NREQ-1:0]  operand A, requester i at [4i+3:4i]
//   i_b_in  [4*NREQ-1:0]  operand B, same packing
//   i_op_in [3*NREQ-1:0]  opcode, requester i at [3i+2:3i]
//   o_grant [NREQ-1:0]    one-cycle one-hot grant pulse
//   o_busy                high while the FSM is not idle
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_id/o_rsp_data/o_rsp_err  response payload
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req,
    input  logic [4*NREQ-1:0] i_a_in,
    input  logic [4*NREQ-1:0] i_b_in,
    input  logic [3*NREQ-1:0] i_op_in,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_busy,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [7:0]        o_rsp_data,
    output logic              o_rsp_err
);

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_last;
    logic [3:0]      r_a;
    logic [3:0]      r_b;
    opcode_t         r_op;
    logic [IDW-1:0]  r_id;
    logic [NREQ-1:0] r_grant;
    logic            r_rspValid;
    logic [IDW-1:0]  r_rspId;
    logic [7:0]      r_rspData;
    logic            r_rspErr;

    logic [NREQ-1:0] w_pickOneHot;
    logic [IDW-1:0]  w_pickId;
    logic [7:0]      w_aluData;
    logic            w_aluErr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_onehot (w_pickOneHot),
        .o_id     (w_pickId)
    );

    // Shared ALU on the latched operands; operands are zero-extended to the
    // 8-bit result width so subtraction wraps modulo 256.
    always_comb begin
        w_aluData = 8'h00;
        w_aluErr  = 1'b0;
        case (r_op)
            OP_ADD:  w_aluData = {4'h0, r_a} + {4'h0, r_b};
            OP_SUB:  w_aluData = {4'h0, r_a} - {4'h0, r_b};
            OP_AND:  w_aluData = {4'h0, r_a & r_b};
            OP_XOR:  w_aluData = {4'h0, r_a ^ r_b};
            OP_CAT:  w_aluData = {r_a, r_b};
            OP_RAND: w_aluData = {7'b0, &r_a};
            default: w_aluErr  = 1'b1;
        endcase
    end

    // Transaction FSM. The pointer starts at NREQ-1 so requester 0 has top
    // priority after reset. Requests are only sampled in IDLE; anything
    // raised during EXEC/RESP simply waits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_last     <= IDW'(NREQ - 1);
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_id       <= '0;
            r_grant    <= '0;
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req != '0) begin
                        r_a     <= i_a_in[4*w_pickId +: 4];
                        r_b     <= i_b_in[4*w_pickId +: 4];
                        r_op    <= i_op_in[3*w_pickId +: 3];
                        r_id    <= w_pickId;
                        r_last  <= w_pickId;
                        r_grant <= w_pickOneHot;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_grant    <= '0;
                    r_rspData  <= w_aluData;
                    r_rspErr   <= w_aluErr;
                    r_rspId    <= r_id;
                    r_rspValid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (r_rspValid && i_rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant    <= '0;
                    r_rspValid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_rsp_valid = r_rspValid;
    assign o_rsp_id    = r_rspId;
    assign o_rsp_data  = r_rspData;
    assign o_rsp_err   = r_rspErr;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed and randomized bench for alu_share_arbiter. The reference model
// picks winners by rotating distance from the previous winner and computes
// results with integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] aIn;
    logic [4*NREQ-1:0] bIn;
    logic [3*NREQ-1:0] opIn;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              rspValid;
    logic              rspReady;
    logic [IDW-1:0]    rspId;
    logic [7:0]        rspData;
    logic              rspErr;

    int compared   = 0;
    int mismatched = 0;
    int modelLast  = NREQ - 1;

    alu_share_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_a_in      (aIn),
        .i_b_in      (bIn),
        .i_op_in     (opIn),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_id    (rspId),
        .o_rsp_data  (rspData),
        .o_rsp_err   (rspErr)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run never finishes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Winner = pending requester with the smallest rotating distance
    // after the previous winner
    function automatic int expWinner(input logic [NREQ-1:0] pend, input int last);
        int best;
        int bestDist;
        int d;
        best     = -1;
        bestDist = NREQ + 1;
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                d = (i - last - 1 + 2 * NREQ) % NREQ;
                if (d < bestDist) begin
                    bestDist = d;
                    best     = i;
                end
            end
        end
        return best;
    endfunction

    // Expected {err, data} from the opcode table
    function automatic logic [8:0] expAlu(input int a, input int b, input int op);
        int   r;
        logic e;
        r = 0;
        e = 1'b0;
        case (op)
            0:       r = (a + b) % 256;
            1:       r = (a - b + 256) % 256;
            2:       r = a & b;
            3:       r = a ^ b;
            4:       r = a * 16 + b;
            5:       r = (a == 15) ? 1 : 0;
            default: e = 1'b1;
        endcase
        return {e, 8'(r)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Load one requester's operands and raise its request
    task automatic applyStimulus(input int idx, input logic [3:0] a,
                                 input logic [3:0] b, input logic [2:0] op);
        aIn[4*idx +: 4] = a;
        bIn[4*idx +: 4] = b;
        opIn[3*idx +: 3] = op;
        req[idx] = 1'b1;
    endtask

    // One full transaction from IDLE with rspReady high: grant, response,
    // handshake. Called on a falling edge while the DUT is idle.
    task automatic serveOne(input string tag);
        int         w;
        logic [8:0] e;
        w = expWinner(req, modelLast);
        if (w < 0) begin
            $display("[TB] %s: nothing pending", tag);
            return;
        end
        e = expAlu(int'(aIn[4*w +: 4]), int'(bIn[4*w +: 4]), int'(opIn[3*w +: 3]));
        @(negedge clk);
        checkOutput($sformatf("%s grant", tag), 32'(grant), 32'(1) << w);
        checkOutput($sformatf("%s busy", tag), 32'(busy), 32'd1);
        req[w]    = 1'b0;
        modelLast = w;
        @(negedge clk);
        checkOutput($sformatf("%s grant drop", tag), 32'(grant), 32'd0);
        checkOutput($sformatf("%s valid", tag), 32'(rspValid), 32'd1);
        checkOutput($sformatf("%s data", tag), 32'(rspData), 32'(e[7:0]));
        checkOutput($sformatf("%s id", tag), 32'(rspId), 32'(w));
        checkOutput($sformatf("%s err", tag), 32'(rspErr), 32'(e[8]));
        @(negedge clk);
        checkOutput($sformatf("%s valid clr", tag), 32'(rspValid), 32'd0);
        checkOutput($sformatf("%s idle", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0]     heldData;
        logic [IDW-1:0] heldId;
        int             w;

        rst      = 1'b1;
        req      = '0;
        aIn      = '0;
        bIn      = '0;
        opIn     = '0;
        rspReady = 1'b1;

        // Reset state
        #3;
        checkOutput("reset grant", 32'(grant), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset valid", 32'(rspValid), 32'd0);
        checkOutput("reset data", 32'(rspData), 32'd0);
        checkOutput("reset id", 32'(rspId), 32'd0);
        checkOutput("reset err", 32'(rspErr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single request: 1 + 2
        applyStimulus(0, 4'h1, 4'h2, 3'b000);
        serveOne("single");
        checkOutput("single literal", 32'(rspData), 32'h03);

        // Op sweep on requester 2
        for (int op = 0; op < 5; op++) begin
            applyStimulus(2, 4'hA, 4'h5, 3'(op));
            serveOne($sformatf("sweep op%0d", op));
        end
        applyStimulus(2, 4'hF, 4'h0, 3'b101);
        serveOne("sweep rand");
        checkOutput("sweep rand literal", 32'(rspData), 32'h01);
        applyStimulus(2, 4'h1, 4'h2, 3'b001);
        serveOne("sweep wrap");
        checkOutput("sweep wrap literal", 32'(rspData), 32'hFF);

        // Fairness: all four held, then 0 and 3
        modelLast = 2;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 4'(i + 1), 4'(i), 3'b000);
        for (int i = 0; i < NREQ; i++) serveOne($sformatf("fair all %0d", i));
        applyStimulus(0, 4'h3, 4'h3, 3'b011);
        applyStimulus(3, 4'h7, 4'h1, 3'b100);
        serveOne("fair 0of03");
        serveOne("fair 3of03");

        // Illegal opcodes still get granted and answered
        applyStimulus(1, 4'h9, 4'h9, 3'b110);
        serveOne("illegal 110");
        checkOutput("illegal err literal", 32'(rspErr), 32'd1);
        applyStimulus(1, 4'h9, 4'h9, 3'b111);
        serveOne("illegal 111");

        // Backpressure: response for requester 3 held while 1 waits
        rspReady = 1'b0;
        applyStimulus(3, 4'hC, 4'h3, 3'b000);
        @(negedge clk);
        checkOutput("bp grant3", 32'(grant), 32'h8);
        req[3]    = 1'b0;
        modelLast = 3;
        applyStimulus(1, 4'h6, 4'h2, 3'b001);
        @(negedge clk);
        heldData = rspData;
        heldId   = rspId;
        checkOutput("bp first data", 32'(rspData), 32'h0F);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp valid c%0d", c), 32'(rspValid), 32'd1);
            checkOutput($sformatf("bp data c%0d", c), 32'(rspData), 32'(heldData));
            checkOutput($sformatf("bp id c%0d", c), 32'(rspId), 32'(heldId));
            checkOutput($sformatf("bp nogrant c%0d", c), 32'(grant), 32'd0);
        end
        rspReady = 1'b1;
        @(negedge clk);
        checkOutput("bp release", 32'(rspValid), 32'd0);
        serveOne("bp next");

        // Randomized traffic; operands only change while a requester is idle
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom_range(1, 0) == 1)) begin
                    applyStimulus(i, 4'($urandom), 4'($urandom), 3'($urandom));
                end
            end
            if (req == '0) begin
                applyStimulus(int'($urandom_range(NREQ - 1, 0)), 4'($urandom),
                              4'($urandom), 3'($urandom));
            end
            serveOne($sformatf("rand %0d", it));
        end
        while (req != '0) serveOne("rand drain");

        // Reset in the middle of EXEC
        applyStimulus(2, 4'hF, 4'hF, 3'b000);
        @(negedge clk);
        checkOutput("mid grant", 32'(grant), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid rst grant", 32'(grant), 32'd0);
        checkOutput("mid rst busy", 32'(busy), 32'd0);
        checkOutput("mid rst valid", 32'(rspValid), 32'd0);
        checkOutput("mid rst data", 32'(rspData), 32'd0);
        checkOutput("mid rst id", 32'(rspId), 32'd0);
        checkOutput("mid rst err", 32'(rspErr), 32'd0);
        req = '0;
        @(negedge clk);
        rst       = 1'b0;
        modelLast = NREQ - 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post rst valid c%0d", c), 32'(rspValid), 32'd0);
        end
        applyStimulus(0, 4'h2, 4'h4, 3'b010);
        applyStimulus(3, 4'h8, 4'h8, 3'b000);
        w = expWinner(req, modelLast);
        serveOne("post rst first");
        checkOutput("post rst winner", 32'(modelLast), 32'(w));
        checkOutput("post rst winner0", 32'(rspId), 32'd0);
        serveOne("post rst second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
